// File: rtl/exibe_sequencia_if.sv
// Sequence ROM read port shared between the game FSM and the display block.
// The display drives the address while it owns the port (exibindo=1).
interface exibe_sequencia_if;
    logic [3:0] endereco;
    logic [3:0] dado_mem;

    modport master (
        output endereco,
        input  dado_mem
    );

    modport slave (
        input  endereco,
        output dado_mem
    );
endinterface

// File: rtl/exibe_sequencia.sv
// Plays jogadas 0..limite of the sequence ROM on leds, lit then dark.
// Optional EXIBE_PISCA_FIM_EN: blink all LEDs once after the last jogada.
module exibe_sequencia #(
    parameter int T_ACESO   = 500,
    parameter int T_APAGADO = 250,
    parameter int CNT_W     = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    exibe_sequencia_if.master mem,
    output logic [3:0] leds,
    output logic       exibindo,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        OCIOSO  = 4'h0,
        PREPARA = 4'h1,
        ACESO   = 4'h2,
        APAGADO = 4'h3,
        PROXIMO = 4'h4,
`ifdef EXIBE_PISCA_FIM_EN
        PISCA   = 4'h6,
`endif
        FIM     = 4'hF
    } estado_t;

    localparam logic [CNT_W-1:0] ACESO_FIM   = CNT_W'(T_ACESO - 1);
    localparam logic [CNT_W-1:0] APAGADO_FIM = CNT_W'(T_APAGADO - 1);

    estado_t          estado, estado_n;
    logic [3:0]       endereco_q, endereco_n;
    logic [3:0]       leds_q, leds_n;
    logic [3:0]       limite_reg, limite_n;
    logic [CNT_W-1:0] timer, timer_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_n;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco_q <= '0;
            leds_q     <= '0;
            limite_reg <= '0;
            timer      <= '0;
        end else begin
            endereco_q <= endereco_n;
            leds_q     <= leds_n;
            limite_reg <= limite_n;
            timer      <= timer_n;
        end
    end

    // The address is advanced on entry to PROXIMO so that the edge
    // leaving PROXIMO already sees the ROM word of the new jogada.
    always_comb begin
        estado_n   = estado;
        endereco_n = endereco_q;
        leds_n     = leds_q;
        limite_n   = limite_reg;
        timer_n    = timer;
        unique case (estado)
            OCIOSO: begin
                leds_n = '0;
                if (iniciar) begin
                    endereco_n = '0;
                    estado_n   = PREPARA;
                end
            end
            PREPARA: begin
                endereco_n = '0;
                timer_n    = '0;
                limite_n   = limite;
                leds_n     = mem.dado_mem;
                estado_n   = ACESO;
            end
            ACESO: begin
                if (timer == ACESO_FIM) begin
                    timer_n  = '0;
                    leds_n   = '0;
                    estado_n = APAGADO;
                end else begin
                    timer_n = timer + CNT_W'(1);
                end
            end
            APAGADO: begin
                if (timer == APAGADO_FIM) begin
                    timer_n = '0;
                    if (endereco_q == limite_reg) begin
`ifdef EXIBE_PISCA_FIM_EN
                        leds_n   = 4'b1111;
                        estado_n = PISCA;
`else
                        estado_n = FIM;
`endif
                    end else begin
                        endereco_n = endereco_q + 4'd1;
                        estado_n   = PROXIMO;
                    end
                end else begin
                    timer_n = timer + CNT_W'(1);
                end
            end
            PROXIMO: begin
                leds_n   = mem.dado_mem;
                estado_n = ACESO;
            end
`ifdef EXIBE_PISCA_FIM_EN
            PISCA: begin
                if (timer == ACESO_FIM) begin
                    timer_n  = '0;
                    leds_n   = '0;
                    estado_n = FIM;
                end else begin
                    timer_n = timer + CNT_W'(1);
                end
            end
`endif
            FIM: begin
                estado_n = OCIOSO;
            end
            default: begin
                estado_n = OCIOSO;
            end
        endcase
    end

    assign mem.endereco = endereco_q;
    assign leds         = leds_q;
    assign exibindo     = (estado != OCIOSO);
    assign pronto       = (estado == FIM);
    assign db_estado    = estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia with T_ACESO=4, T_APAGADO=2.
// Define EXIBE_PISCA_FIM_EN to also check the final blink.
module tb_exibe_sequencia;

    localparam int TA = 4;
    localparam int TP = 2;
`ifdef EXIBE_PISCA_FIM_EN
    localparam int PX = TA;
    localparam int PN = 1;
`else
    localparam int PX = 0;
    localparam int PN = 0;
`endif

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] limite  = 4'd0;
    logic [3:0] leds;
    logic       exibindo;
    logic       pronto;
    logic [3:0] db_estado;

    exibe_sequencia_if bus ();

    exibe_sequencia #(
        .T_ACESO   (TA),
        .T_APAGADO (TP),
        .CNT_W     (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .limite    (limite),
        .mem       (bus),
        .leds      (leds),
        .exibindo  (exibindo),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    logic [3:0] rom [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    always_comb bus.dado_mem = rom[bus.endereco[1:0]];

    int total = 0;
    int bad   = 0;

    logic [3:0] seq_q [$];
    int         lit_q [$];
    int         pr_q  [$];
    int         exib_low;
    int         max_end;
    int         pisca_n;

    // Edge 0 is the rising edge that samples iniciar in OCIOSO.
    task automatic start_run(input int lim, input bit hold);
        @(negedge clock);
        limite  = lim[3:0];
        iniciar = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) iniciar = 1'b0;
    endtask

    // Records lit jogadas and the edge index at which pronto is sampled high.
    task automatic watch(input int n_pr, input int budget);
        logic [3:0] prev;
        int st;
        seq_q.delete();
        lit_q.delete();
        pr_q.delete();
        exib_low = 0;
        max_end  = 0;
        pisca_n  = 0;
        prev     = leds;
        st       = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (pr_q.size() == 0 && !exibindo) exib_low++;
            if (int'(bus.endereco) > max_end) max_end = int'(bus.endereco);
            if (leds != 4'b0000 && prev == 4'b0000) begin
                seq_q.push_back(leds);
                st = c;
            end
            if (leds == 4'b0000 && prev != 4'b0000) lit_q.push_back(c - st);
            if (leds == 4'b1111 && db_estado == 4'h6) pisca_n++;
            prev = leds;
            if (pronto) begin
                pr_q.push_back(c + 1);
                if (pr_q.size() == n_pr) break;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if (leds !== 4'b0000 || bus.endereco !== 4'd0) begin
            bad++;
            $display("FAIL reset_out leds=%b end=%0d want 0/0", leds, bus.endereco);
        end
        total++;
        if (exibindo !== 1'b0 || pronto !== 1'b0 || db_estado !== 4'h0) begin
            bad++;
            $display("FAIL reset_st exib=%b pronto=%b est=%h want 0/0/0",
                     exibindo, pronto, db_estado);
        end
        reset = 1'b1;
    endtask

    task automatic test_reset_mid();
        start_run(3, 1'b0);
        repeat (17) @(negedge clock);
        total++;
        if (db_estado !== 4'h2 || bus.endereco !== 4'd2 || leds !== 4'b0100) begin
            bad++;
            $display("FAIL mid_pre est=%h end=%0d leds=%b want 2/2/0100",
                     db_estado, bus.endereco, leds);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (leds !== 4'b0000 || bus.endereco !== 4'd0 || db_estado !== 4'h0) begin
            bad++;
            $display("FAIL mid_rst leds=%b end=%0d est=%h want 0/0/0",
                     leds, bus.endereco, db_estado);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        total++;
        if (db_estado !== 4'h0 || leds !== 4'b0000 || exibindo !== 1'b0) begin
            bad++;
            $display("FAIL mid_idle est=%h leds=%b exib=%b want 0/0/0",
                     db_estado, leds, exibindo);
        end
    endtask

    task automatic test_sequence();
        start_run(3, 1'b0);
        watch(1, 200);
        total++;
        if (pr_q.size() != 1 || pr_q[0] != 29 + PX) begin
            bad++;
            $display("FAIL seq_lat got=%0d want=%0d",
                     (pr_q.size() > 0) ? pr_q[0] : -1, 29 + PX);
        end
        total++;
        if (seq_q.size() != 4 + PN) begin
            bad++;
            $display("FAIL seq_len got=%0d want=%0d", seq_q.size(), 4 + PN);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < seq_q.size()) begin
                total++;
                if (seq_q[i] !== rom[i]) begin
                    bad++;
                    $display("FAIL seq_led%0d got=%b want=%b", i, seq_q[i], rom[i]);
                end
            end
        end
        for (int i = 0; i < lit_q.size(); i++) begin
            total++;
            if (lit_q[i] != TA) begin
                bad++;
                $display("FAIL seq_lit%0d got=%0d want=%0d", i, lit_q[i], TA);
            end
        end
        total++;
        if (exib_low != 0 || max_end != 3) begin
            bad++;
            $display("FAIL seq_exib low=%0d maxend=%0d want 0/3", exib_low, max_end);
        end
        @(negedge clock);
        total++;
        if (pronto !== 1'b0 || db_estado !== 4'h0) begin
            bad++;
            $display("FAIL seq_pulse pronto=%b est=%h want 0/0", pronto, db_estado);
        end
    endtask

    task automatic test_limite_zero();
        start_run(0, 1'b0);
        watch(1, 100);
        total++;
        if (pr_q.size() != 1 || pr_q[0] != 8 + PX) begin
            bad++;
            $display("FAIL zero_lat got=%0d want=%0d",
                     (pr_q.size() > 0) ? pr_q[0] : -1, 8 + PX);
        end
        total++;
        if (seq_q.size() != 1 + PN || seq_q[0] !== 4'b0001) begin
            bad++;
            $display("FAIL zero_seq len=%0d first=%b want %0d/0001",
                     seq_q.size(), (seq_q.size() > 0) ? seq_q[0] : 4'bx, 1 + PN);
        end
        total++;
        if (max_end != 0 || lit_q.size() < 1 || lit_q[0] != TA) begin
            bad++;
            $display("FAIL zero_end maxend=%0d lit=%0d want 0/%0d",
                     max_end, (lit_q.size() > 0) ? lit_q[0] : -1, TA);
        end
    endtask

    task automatic test_limite_max();
        start_run(15, 1'b0);
        watch(1, 400);
        total++;
        if (pr_q.size() != 1 || pr_q[0] != 113 + PX) begin
            bad++;
            $display("FAIL max_lat got=%0d want=%0d",
                     (pr_q.size() > 0) ? pr_q[0] : -1, 113 + PX);
        end
        total++;
        if (seq_q.size() != 16 + PN || max_end != 15) begin
            bad++;
            $display("FAIL max_len len=%0d maxend=%0d want %0d/15",
                     seq_q.size(), max_end, 16 + PN);
        end
        for (int i = 12; i < 16; i++) begin
            if (i < seq_q.size()) begin
                total++;
                if (seq_q[i] !== rom[i % 4]) begin
                    bad++;
                    $display("FAIL max_led%0d got=%b want=%b", i, seq_q[i], rom[i % 4]);
                end
            end
        end
        total++;
        if (bus.endereco !== 4'd15) begin
            bad++;
            $display("FAIL max_wrap end=%0d want 15", bus.endereco);
        end
    endtask

    task automatic test_ignore_iniciar();
        start_run(3, 1'b0);
        fork
            watch(1, 200);
            begin
                repeat (9) @(posedge clock);
                #1;
                iniciar = 1'b1;
                limite  = 4'd1;
                @(posedge clock);
                #1 iniciar = 1'b0;
            end
        join
        total++;
        if (pr_q.size() != 1 || pr_q[0] != 29 + PX) begin
            bad++;
            $display("FAIL ign_lat got=%0d want=%0d",
                     (pr_q.size() > 0) ? pr_q[0] : -1, 29 + PX);
        end
        total++;
        if (seq_q.size() != 4 + PN || max_end != 3) begin
            bad++;
            $display("FAIL ign_len len=%0d maxend=%0d want %0d/3",
                     seq_q.size(), max_end, 4 + PN);
        end
        repeat (4) @(negedge clock);
        total++;
        if (db_estado !== 4'h0 || exibindo !== 1'b0) begin
            bad++;
            $display("FAIL ign_idle est=%h exib=%b want 0/0", db_estado, exibindo);
        end
    endtask

    task automatic test_back_to_back();
        start_run(3, 1'b1);
        watch(2, 300);
        iniciar = 1'b0;
        total++;
        if (pr_q.size() != 2) begin
            bad++;
            $display("FAIL b2b_cnt got=%0d want=2", pr_q.size());
        end else begin
            total++;
            if (pr_q[0] != 29 + PX) begin
                bad++;
                $display("FAIL b2b_lat got=%0d want=%0d", pr_q[0], 29 + PX);
            end
            total++;
            if (pr_q[1] - pr_q[0] != 30 + PX) begin
                bad++;
                $display("FAIL b2b_gap got=%0d want=%0d", pr_q[1] - pr_q[0], 30 + PX);
            end
        end
        total++;
        if (seq_q.size() != 2 * (4 + PN)) begin
            bad++;
            $display("FAIL b2b_len got=%0d want=%0d", seq_q.size(), 2 * (4 + PN));
        end
        repeat (3) @(negedge clock);
    endtask

`ifdef EXIBE_PISCA_FIM_EN
    task automatic test_pisca();
        start_run(1, 1'b0);
        watch(1, 100);
        total++;
        if (pr_q.size() != 1 || pr_q[0] != 19) begin
            bad++;
            $display("FAIL pisca_lat got=%0d want=19",
                     (pr_q.size() > 0) ? pr_q[0] : -1);
        end
        total++;
        if (seq_q.size() != 3 || seq_q[0] !== 4'b0001 ||
            seq_q[1] !== 4'b0010 || seq_q[2] !== 4'b1111) begin
            bad++;
            $display("FAIL pisca_seq len=%0d want 3 with 0001,0010,1111", seq_q.size());
        end
        total++;
        if (pisca_n != TA) begin
            bad++;
            $display("FAIL pisca_cyc got=%0d want=%0d", pisca_n, TA);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid();
        test_sequence();
        test_limite_zero();
        test_limite_max();
        test_ignore_iniciar();
        test_back_to_back();
`ifdef EXIBE_PISCA_FIM_EN
        test_pisca();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog bench did not finish by t=%0t", $time);
        $fatal(1);
    end

endmodule
